// File: rtl/mag_cmp_ctrl.sv
// Operand-entry / compare / display sequencer for the 5-bit magnitude-compare lab datapath.
// Loads X and Y on button presses, captures the comparator result, and holds it on the display.
module mag_cmp_ctrl #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_MAX     = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  sw,
    input  logic        btn,
    input  logic [4:0]  abs_in,
    input  logic        gt_in,
    input  logic        eq_in,
    input  logic        lt_in,
    output logic [4:0]  x_out,
    output logic [4:0]  y_out,
    output logic [13:0] cnt1,
    output logic [13:0] cnt2,
    output logic        valid,
    output logic        sign,
    output logic [1:0]  state_led
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] WAIT_X = 2'b00;
    localparam logic [1:0] WAIT_Y = 2'b01;
    localparam logic [1:0] SETTLE = 2'b10;
    localparam logic [1:0] SHOW   = 2'b11;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [13:0]   CNT_SAT   = 14'(CNT_MAX);

    logic [1:0]    state_q, state_d;
    logic [4:0]    x_q, x_d;
    logic [4:0]    y_q, y_d;
    logic [4:0]    abs_q, abs_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          btn_q;
    logic          press;

    // Sign is taken from lt, so gt is only tied off here.
    logic unused_gt;
    assign unused_gt = gt_in;

    assign press = btn & ~btn_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        abs_d   = abs_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_X: begin
                if (press) begin
                    x_d     = sw;
                    state_d = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (press) begin
                    y_d     = sw;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                abs_d   = abs_in;
                lt_d    = lt_in;
                eq_d    = eq_in;
                cnt_d   = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + 14'd1;
                hold_d  = '0;
                state_d = SHOW;
            end
            default: begin
                hold_d = hold_q + HW'(1);
                // A press and a timeout in the same cycle both land in WAIT_X.
                if (press || (hold_q == HOLD_LAST)) begin
                    state_d = WAIT_X;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        btn_q <= btn;
        if (rst) begin
            state_q <= WAIT_X;
            x_q     <= '0;
            y_q     <= '0;
            abs_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            abs_q   <= abs_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        cnt2  = {9'b0, sw};
        valid = 1'b1;
        sign  = 1'b0;
        case (state_q)
            SETTLE: begin
                cnt2  = '0;
                valid = 1'b0;
            end
            SHOW: begin
                cnt2  = {9'b0, abs_q};
                valid = ~eq_q;
                sign  = lt_q & ~eq_q;
            end
            default: ;
        endcase
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign cnt1      = cnt_q;
    assign state_led = state_q;

endmodule
